// File: rtl/key_expand_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl_pkg
// Shared constants and types for the AES-128 key-expansion sequencer.
//   AES_KEY_W       : key / round-key width
//   AES_NUM_ROUNDS  : number of rounds to expand (round keys 0..AES_NUM_ROUNDS)
//   AES_KS_LATENCY  : edges from ks_key/ks_rnd change until ks_next is valid
//   RK_ADDR_W       : width of round index / round-key store address
//   state_e         : sequencer states
// -----------------------------------------------------------------------------
package key_expand_ctrl_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_KS_LATENCY = 4;
    localparam int RK_ADDR_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/key_expand_ctrl_round_key_store.sv
// -----------------------------------------------------------------------------
// round_key_store
// Register file holding round keys 0..DEPTH-1.
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (clears read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  registered read data, 0 for addresses >= DEPTH
// -----------------------------------------------------------------------------
module round_key_store #(
    parameter int KEY_W  = 128,
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [KEY_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [KEY_W-1:0]  rd_data
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] rd_data_q;

    // Storage is never cleared; a write coinciding with reset is dropped so
    // a reset mid-expansion cannot leave a half-updated entry behind.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && (wr_addr < ADDR_W'(DEPTH))) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read: a read of an entry on its write edge returns the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_addr < ADDR_W'(DEPTH)) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl
// Sequencer around an external single-round key-schedule pipeline. Accepts a
// cipher key, iterates it through the pipeline NUM_ROUNDS times and stores
// every round key for the cipher datapath.
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   key_in      in   cipher key
//   key_valid   in   key_in valid
//   key_ready   out  1 in IDLE or DONE
//   ks_key      out  previous round key to the round pipeline (held stable)
//   ks_rnd      out  round index to the round pipeline (selects rcon)
//   ks_next     in   next round key from the round pipeline
//   busy        out  expansion running
//   keys_valid  out  all round keys stored and coherent
//   rk_rd_addr  in   round-key read address
//   rk_rd_data  out  round key at rk_rd_addr, 1-cycle latency
// -----------------------------------------------------------------------------
module key_expand_ctrl
    import key_expand_ctrl_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int KS_LATENCY = AES_KS_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_W-1:0]     key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [KEY_W-1:0]     ks_key,
    output logic [RK_ADDR_W-1:0] ks_rnd,
    input  logic [KEY_W-1:0]     ks_next,
    output logic                 busy,
    output logic                 keys_valid,
    input  logic [RK_ADDR_W-1:0] rk_rd_addr,
    output logic [KEY_W-1:0]     rk_rd_data
);

    localparam int                   CNT_W    = $clog2(KS_LATENCY + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(KS_LATENCY);
    localparam logic [RK_ADDR_W-1:0] RND_LAST = RK_ADDR_W'(NUM_ROUNDS);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0]       ks_key_q, ks_key_d;
    logic [RK_ADDR_W-1:0]   ks_rnd_q, ks_rnd_d;
    logic [RK_ADDR_W-1:0]   rnd_inc;
    logic                   accept;
    logic                   capture;
    logic                   wr_en;
    logic [RK_ADDR_W-1:0]   wr_addr;
    logic [KEY_W-1:0]       wr_data;

    assign accept  = key_valid & key_ready;
    // The pipeline output is first complete KS_LATENCY edges after ks_key
    // changed; cnt reaches KS_LATENCY on that edge, so capture on the next.
    assign capture = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign rnd_inc = ks_rnd_q + 1'b1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (accept) state_d = ST_RUN;
            ST_RUN:           if (capture && (rnd_inc == RND_LAST)) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: key_ready = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
            end
            default: key_ready = 1'b0;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ks_key_q <= '0;
            ks_rnd_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ks_key_q <= ks_key_d;
            ks_rnd_q <= ks_rnd_d;
        end
    end

    // ks_key/ks_rnd only move on the accept edge or a capture edge so the
    // round pipeline sees stable operands for the whole wait.
    always_comb begin
        cnt_d    = cnt_q;
        ks_key_d = ks_key_q;
        ks_rnd_d = ks_rnd_q;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = key_in;
        if (accept) begin
            cnt_d    = '0;
            ks_key_d = key_in;
            ks_rnd_d = '0;
            wr_en    = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (capture) begin
                cnt_d    = '0;
                ks_key_d = ks_next;
                wr_en    = 1'b1;
                wr_addr  = rnd_inc;
                wr_data  = ks_next;
                // On the final round ks_rnd holds its last value.
                if (rnd_inc < RND_LAST) begin
                    ks_rnd_d = rnd_inc;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign ks_key = ks_key_q;
    assign ks_rnd = ks_rnd_q;

    round_key_store #(
        .KEY_W  (KEY_W),
        .DEPTH  (NUM_ROUNDS + 1),
        .ADDR_W (RK_ADDR_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rk_rd_addr),
        .rd_data (rk_rd_data)
    );

endmodule

// File: tb/tb_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_expand_ctrl
// Pairs key_expand_ctrl with a 4-stage AES-128 key-schedule round pipeline and
// checks stored round keys through a scoreboard queue plus FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_key_expand_ctrl;
    import key_expand_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] ks_key;
    logic [3:0]   ks_rnd;
    logic [127:0] ks_next;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;

    always #5 clk = ~clk;

    key_expand_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .ks_key     (ks_key),
        .ks_rnd     (ks_rnd),
        .ks_next    (ks_next),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_rd_addr (rk_rd_addr),
        .rk_rd_data (rk_rd_data)
    );

    // ---------------- AES-128 key schedule round ----------------
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        int col;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        col = int'(b[3:0]);
        return row[127 - 8*col -: 8];
    endfunction

    function automatic logic [7:0] rcon(input int r);
        case (r)
            0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
            4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
            8: return 8'h1b;  default: return 8'h36;
        endcase
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        t  = t ^ {rcon(r), 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round pipeline: result complete 4 edges after its operands change.
    logic [127:0] pipe_q [4];
    always @(posedge clk) begin
        pipe_q[0] <= next_rk(ks_key, int'(ks_rnd));
        pipe_q[1] <= pipe_q[0];
        pipe_q[2] <= pipe_q[1];
        pipe_q[3] <= pipe_q[2];
    end
    assign ks_next = pipe_q[3];

    // ---------------- Scoreboard / checking ----------------
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q [$];
    logic [127:0] cur_rk [11];
    logic [127:0] prev_rk10;
    logic [127:0] a_rk10;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_fill(input logic [127:0] k);
        cur_rk[0] = k;
        for (int r = 1; r <= 10; r++) cur_rk[r] = next_rk(cur_rk[r-1], r - 1);
    endtask

    task automatic push_exp();
        for (int r = 0; r <= 10; r++) exp_q.push_back(cur_rk[r]);
    endtask

    // Called at a negedge with key_ready expected high; returns at the
    // negedge right after the accept edge (cycle j=0 of the expansion).
    task automatic accept(input logic [127:0] k);
        chk("acc_rdy", key_ready, 1);
        key_in    = k;
        key_valid = 1'b1;
        model_fill(k);
        @(negedge clk);
        key_valid = 1'b0;
        $display("accept key=%h", k);
    endtask

    task automatic watch(input int from_j, input int to_j);
        for (int j = from_j; j <= to_j; j++) begin
            chk($sformatf("ks_rnd_j%0d", j), ks_rnd, j / 5);
            chk($sformatf("busy_j%0d", j), busy, 1);
            chk($sformatf("kready_j%0d", j), key_ready, 0);
            if (j % 5 == 0) chk($sformatf("ks_key_j%0d", j), ks_key, cur_rk[j / 5]);
            if (j == 49) chk("kv_early", keys_valid, 0);
            @(negedge clk);
        end
    endtask

    task automatic finish_chk();
        chk("kv_done", keys_valid, 1);
        chk("busy_done", busy, 0);
        chk("kready_done", key_ready, 1);
        chk("ks_rnd_done", ks_rnd, 9);
        chk("ks_key_done", ks_key, cur_rk[10]);
        prev_rk10 = cur_rk[10];
    endtask

    task automatic sweep();
        logic [127:0] e;
        for (int a = 0; a <= 10; a++) begin
            rk_rd_addr = 4'(a);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rk%0d", a), rk_rd_data, e);
                $display("read rk[%0d]=%h", a, rk_rd_data);
            end
        end
        rk_rd_addr = 4'd11;
        @(negedge clk);
        chk("rd_addr11", rk_rd_data, 0);
        rk_rd_addr = 4'd15;
        @(negedge clk);
        chk("rd_addr15", rk_rd_data, 0);
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [127:0] e, input string tag);
        rk_rd_addr = a;
        @(negedge clk);
        chk(tag, rk_rd_data, e);
    endtask

    task automatic full_run(input logic [127:0] k);
        accept(k);
        push_exp();
        watch(0, 49);
        finish_chk();
        sweep();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
        rk_rd_addr = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_kready", key_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_kv", keys_valid, 0);
        chk("rst_ks_key", ks_key, 0);
        chk("rst_ks_rnd", ks_rnd, 0);
        chk("rst_rd", rk_rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 key
        full_run(128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_chk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");

        // All-zero key, accepted from DONE
        full_run(128'h0);
        read_chk(4'd1, 128'h62636363626363636263636362636363, "zero_rk1");
        read_chk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // key_valid held during RUN with a different key: ignored
        k = {$urandom, $urandom, $urandom, $urandom};
        accept(k);
        push_exp();
        key_valid = 1'b1;
        key_in    = ~k;
        watch(0, 48);
        key_valid = 1'b0;
        watch(49, 49);
        finish_chk();
        sweep();

        // Reset at cycle 20 of an expansion: partial result discarded
        accept({$urandom, $urandom, $urandom, $urandom});
        watch(0, 19);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_kready", key_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_kv", keys_valid, 0);
        chk("mid_rst_ks_rnd", ks_rnd, 0);
        exp_q.delete();
        full_run({$urandom, $urandom, $urandom, $urandom});

        // Back-to-back: key B accepted in the cycle keys_valid rises for A
        accept({$urandom, $urandom, $urandom, $urandom});
        watch(0, 48);
        rk_rd_addr = 4'd10;
        watch(49, 49);
        chk("rd_old_on_write", rk_rd_data, prev_rk10);
        finish_chk();
        a_rk10 = cur_rk[10];
        accept({$urandom, $urandom, $urandom, $urandom});
        chk("b2b_kv_fall", keys_valid, 0);
        chk("b2b_rd_a_rk10", rk_rd_data, a_rk10);
        push_exp();
        watch(0, 49);
        finish_chk();
        sweep();

        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
